// File: rtl/msg_poly_sequencer.sv
// Expands a registered 256-bit Kyber message into message-polynomial coefficients,
// streamed LANES per beat into the polynomial RAM write port with backpressure.
//
// state  | meaning
// IDLE   | waiting for a message, msg_ready high
// RUN    | issuing write beats in ascending address order
// DONE   | one-cycle completion pulse, then back to IDLE
module msg_poly_sequencer #(
    parameter int KYBER_N       = 256,
    parameter int KYBER_R_WIDTH = 12,
    parameter int KYBER_Q       = 3329,
    parameter int LANES         = 4,
    parameter int ADDR_W        = $clog2(KYBER_N / LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           msg_valid,
    output logic                           msg_ready,
    input  logic [KYBER_N-1:0]             msg_in,
    output logic                           wr_en,
    input  logic                           wr_ready,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [LANES*KYBER_R_WIDTH-1:0] wr_data,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W = $clog2(KYBER_N);
    localparam int LANE_SH = $clog2(LANES);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(KYBER_N / LANES - 1);
    localparam logic [KYBER_R_WIDTH-1:0] ONE_VAL = KYBER_R_WIDTH'((KYBER_Q + 1) / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [KYBER_N-1:0] msg_reg;
    logic [ADDR_W-1:0]  beat_cnt;
    logic               load_msg;
    logic               advance;
    logic [IDX_W-1:0]   base;
    logic [LANES-1:0]   lane_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            msg_reg  <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_n;
            if (load_msg) begin
                msg_reg  <= msg_in;
                beat_cnt <= '0;
            end else if (advance) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        msg_ready = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load_msg  = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    load_msg = 1'b1;
                    state_n  = S_RUN;
                end
            end
            S_RUN: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (wr_ready) begin
                    if (beat_cnt == LAST_BEAT) state_n = S_DONE;
                    else advance = 1'b1;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Address and data are forced to zero outside RUN so the bus is quiet when idle.
    assign base      = IDX_W'(beat_cnt) << LANE_SH;
    assign lane_bits = msg_reg[base +: LANES];

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (state == S_RUN) begin
            wr_addr = beat_cnt;
            for (int j = 0; j < LANES; j++) begin
                wr_data[j*KYBER_R_WIDTH +: KYBER_R_WIDTH] = lane_bits[j] ? ONE_VAL : '0;
            end
        end
    end

endmodule

// File: tb/tb_msg_poly_sequencer.sv
// Directed bench for msg_poly_sequencer: decode patterns, latency, stalls,
// back-to-back acceptance and mid-stream reset.
module tb_msg_poly_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         msg_valid;
    logic         msg_ready;
    logic [255:0] msg_in;
    logic         wr_en;
    logic         wr_ready;
    logic [5:0]   wr_addr;
    logic [47:0]  wr_data;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] obs [64];

    msg_poly_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_in    (msg_in),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] beat_model(input logic [255:0] m, input int k);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) r[j*12 +: 12] = m[k*4 + j] ? 12'd1665 : 12'd0;
        return r;
    endfunction

    // Entered just after acceptance (first RUN cycle, at a negedge); leaves at the
    // negedge of the IDLE cycle that follows done.
    task automatic check_stream(input logic [255:0] m, input int stall_pct, input string name);
        int k = 0;
        int cyc = 1;
        int budget = 0;
        logic stalled = 1'b0;
        logic [5:0]  pa = '0;
        logic [47:0] pd = '0;
        while (k < 64 && budget < 3000) begin
            wr_ready = ($urandom_range(0, 99) >= stall_pct);
            n_checks++;
            if (wr_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || msg_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run_ctrl beat %0d: wr_en=%0b busy=%0b done=%0b msg_ready=%0b required 1 1 0 0",
                         name, k, wr_en, busy, done, msg_ready);
            end
            n_checks++;
            if (wr_addr !== 6'(k)) begin
                n_fail++;
                $display("FAIL %s wr_addr got %0d required %0d", name, wr_addr, k);
            end
            n_checks++;
            if (wr_data !== beat_model(m, k)) begin
                n_fail++;
                $display("FAIL %s wr_data beat %0d got %h required %h", name, k, wr_data, beat_model(m, k));
            end
            if (stalled) begin
                n_checks++;
                if (wr_addr !== pa || wr_data !== pd) begin
                    n_fail++;
                    $display("FAIL %s stall_hold got %0d/%h required %0d/%h", name, wr_addr, wr_data, pa, pd);
                end
            end
            obs[k]  = wr_data;
            stalled = !wr_ready;
            pa      = wr_addr;
            pd      = wr_data;
            if (wr_ready) k++;
            @(negedge clk);
            cyc++;
            budget++;
        end
        n_checks++;
        if (k < 64) begin
            n_fail++;
            $display("FAIL %s timeout beats got %0d required 64", name, k);
        end
        n_checks++;
        if (done !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b1 || msg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_cycle: done=%0b wr_en=%0b busy=%0b msg_ready=%0b required 1 0 1 0",
                     name, done, wr_en, busy, msg_ready);
        end
        if (stall_pct == 0) begin
            n_checks++;
            if (cyc !== 65) begin
                n_fail++;
                $display("FAIL %s done_latency got cycle %0d required 65", name, cyc);
            end
        end
        @(negedge clk);
        n_checks++;
        if (msg_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back_to_idle: msg_ready=%0b done=%0b busy=%0b wr_en=%0b required 1 0 0 0",
                     name, msg_ready, done, busy, wr_en);
        end
    endtask

    task automatic run_msg(input logic [255:0] m, input int stall_pct, input string name);
        msg_valid = 1'b1;
        msg_in    = m;
        n_checks++;
        if (msg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept msg_ready got %0b required 1", name, msg_ready);
        end
        @(negedge clk);
        msg_valid = 1'b0;
        msg_in    = ~m;
        check_stream(m, stall_pct, name);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        msg_valid = 1'b1;
        msg_in    = '1;
        wr_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (msg_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: msg_ready=%0b wr_en=%0b busy=%0b done=%0b required 1 0 0 0",
                     msg_ready, wr_en, busy, done);
        end
        n_checks++;
        if (wr_addr !== 6'd0 || wr_data !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_bus: wr_addr=%0d wr_data=%h required 0 0", wr_addr, wr_data);
        end
        rst       = 1'b0;
        msg_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b0 || msg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_capture: wr_en=%0b msg_ready=%0b required 0 1", wr_en, msg_ready);
        end
    endtask

    task automatic test_zero_msg();
        run_msg(256'd0, 0, "zero");
    endtask

    task automatic test_all_ones();
        int bad = 0;
        run_msg({256{1'b1}}, 0, "ones");
        for (int i = 0; i < 64; i++) if (obs[i] !== 48'h681681681681) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ones_const beats_wrong got %0d required 0 (beat0=%h)", bad, obs[0]);
        end
    endtask

    task automatic test_single_bits();
        int bad = 0;
        run_msg(256'h1, 0, "bit0");
        n_checks++;
        if (obs[0] !== 48'h000000000681) begin
            n_fail++;
            $display("FAIL bit0_beat0 got %h required 000000000681", obs[0]);
        end
        for (int i = 1; i < 64; i++) if (obs[i] !== 48'd0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bit0_rest nonzero_beats got %0d required 0", bad);
        end
        run_msg(256'h1 << 255, 0, "bit255");
        n_checks++;
        if (obs[63] !== 48'h681000000000) begin
            n_fail++;
            $display("FAIL bit255_beat63 got %h required 681000000000", obs[63]);
        end
        n_checks++;
        if (obs[0] !== 48'd0) begin
            n_fail++;
            $display("FAIL bit255_beat0 got %h required 0", obs[0]);
        end
    endtask

    task automatic test_backpressure();
        run_msg(256'h5c5d501a5670243b8fc6d100cf96e25f174ba1e6a5bf2407a51b51727175978a, 50, "stall");
    endtask

    task automatic test_back_to_back();
        logic [255:0] a = {8{32'hf00f1234}};
        logic [255:0] b = {8{32'h0ff05a5a}};
        msg_valid = 1'b1;
        msg_in    = a;
        n_checks++;
        if (msg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b accept msg_ready got %0b required 1", msg_ready);
        end
        @(negedge clk);
        msg_in = b;
        check_stream(a, 0, "b2b_first");
        @(negedge clk);
        msg_valid = 1'b0;
        msg_in    = '0;
        check_stream(b, 0, "b2b_second");
    endtask

    task automatic test_reset_midstream();
        int guard = 0;
        int stray = 0;
        msg_valid = 1'b1;
        msg_in    = {8{32'h13579bdf}};
        wr_ready  = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        while (wr_addr !== 6'd10 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (wr_addr !== 6'd10 || wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst reach_beat10 got addr %0d wr_en %0b required 10 1", wr_addr, wr_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (wr_en !== 1'b0 || msg_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || wr_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL midrst idle_values: wr_en=%0b msg_ready=%0b done=%0b busy=%0b wr_addr=%0d required 0 1 0 0 0",
                     wr_en, msg_ready, done, busy, wr_addr);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || done !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL midrst stray_activity got %0d cycles required 0", stray);
        end
        run_msg(256'he9daa4f73c1b8e0257fa9d16b04c2e816d3a9f50c72e41b80f95a6d31e7c9682, 30, "after_rst");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_msg();
        test_all_ones();
        test_single_bits();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
